// File: rtl/lut_probe_pkg.sv
// Shared types and constants for the LUT truth-table probe.
// The IA..ID words are the LUT_INIT patterns of the individual inputs a, b, c and d.
package lut_probe_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    localparam logic [15:0] IA = 16'hAAAA;
    localparam logic [15:0] IB = 16'hCCCC;
    localparam logic [15:0] IC = 16'hF0F0;
    localparam logic [15:0] ID = 16'hFF00;

    // One bit set for each table entry that an n_in-input sweep actually visits.
    function automatic logic [15:0] tt_mask(input int unsigned n_in);
        logic [31:0] m;
        m = (32'd1 << (32'd1 << n_in)) - 32'd1;
        return m[15:0];
    endfunction

endpackage

// File: rtl/lut_probe_sync_bit.sv
// Reset-to-zero flop chain that brings the asynchronous cell output into the clk domain.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;
    logic [STAGES-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/lut_probe.sv
// Drives every {d,c,b,a} combination into a cell under test and rebuilds its
// LUT_INIT word; each entry waits SETTLE_CYCLES+SYNC_STAGES cycles, then samples once.
module lut_probe
    import lut_probe_pkg::*;
#(
    parameter int N_IN          = 4,
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] expected,
    output logic [3:0]  probe_in,
    input  logic        probe_out,
    output logic        busy,
    output logic        done,
    output logic [15:0] table_o,
    output logic        match
);

    localparam int W       = SETTLE_CYCLES + SYNC_STAGES;
    localparam int CW      = $clog2(W);
    localparam int IW      = N_IN + 1;
    localparam int ENTRIES = 1 << N_IN;

    localparam logic [CW-1:0] CNT_INIT = CW'(W - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(ENTRIES - 1);
    localparam logic [15:0]   MASK     = tt_mask(N_IN);

    state_e        state_q,    state_d;
    logic [IW-1:0] idx_q,      idx_d;
    logic [CW-1:0] cnt_q,      cnt_d;
    logic [15:0]   shadow_q,   shadow_d;
    logic [3:0]    probe_in_q, probe_in_d;
    logic          busy_q,     busy_d;
    logic          done_q,     done_d;
    logic [15:0]   table_q,    table_d;
    logic          match_q,    match_d;

    logic          sync_out;
    logic [3:0]    idx_lo;
    logic [15:0]   shadow_sampled;

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (probe_out),
        .q   (sync_out)
    );

    assign idx_lo = 4'(idx_q);

    always_comb begin
        shadow_sampled         = shadow_q;
        shadow_sampled[idx_lo] = sync_out;

        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        probe_in_d = probe_in_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        table_d    = table_q;
        match_d    = match_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    probe_in_d = '0;
                    idx_d      = '0;
                    cnt_d      = CNT_INIT;
                    busy_d     = 1'b1;
                    state_d    = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_SAMPLE: begin
                shadow_d = shadow_sampled;
                // Results and the done pulse are registered together so they appear in the DONE cycle.
                if (idx_q == IDX_LAST) begin
                    table_d = shadow_sampled & MASK;
                    match_d = ((shadow_sampled ^ expected) & MASK) == 16'h0000;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d      = idx_q + 1'b1;
                    probe_in_d = 4'(idx_q + 1'b1) & MASK[3:0] | 4'(idx_q + 1'b1) & 4'(ENTRIES - 1);
                    cnt_d      = CNT_INIT;
                    state_d    = S_SETTLE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cnt_q      <= '0;
            shadow_q   <= '0;
            probe_in_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            table_q    <= '0;
            match_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            probe_in_q <= probe_in_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            table_q    <= table_d;
            match_q    <= match_d;
        end
    end

    assign probe_in = probe_in_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign table_o  = table_q;
    assign match    = match_q;

endmodule

// File: tb/tb_lut_probe.sv
// Bench for lut_probe: a 4-input and a 2-input probe each sweep a behavioural LUT cell
// with a propagation delay; a scoreboard checks table, match and done timing.
module tb_lut_probe;
    import lut_probe_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // {dut_is_b, done cycle[15:0], match, table[15:0]}
    logic [33:0] exp_q[$];

    logic        start_a = 1'b0, start_b = 1'b0;
    logic [15:0] exp_a = '0, exp_b = '0, lut_a = '0, lut_b = '0;
    logic [3:0]  pin_a, pin_b;
    logic        pout_a, pout_b;
    logic        busy_a, busy_b, done_a, done_b, match_a, match_b;
    logic [15:0] tab_a, tab_b;

    assign #1 pout_a = lut_a[pin_a];
    assign #1 pout_b = lut_b[pin_b];

    lut_probe #(.N_IN(4), .SETTLE_CYCLES(4), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .expected(exp_a),
        .probe_in(pin_a), .probe_out(pout_a), .busy(busy_a), .done(done_a),
        .table_o(tab_a), .match(match_a)
    );

    lut_probe #(.N_IN(2), .SETTLE_CYCLES(4), .SYNC_STAGES(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .expected(exp_b),
        .probe_in(pin_b), .probe_out(pout_b), .busy(busy_b), .done(done_b),
        .table_o(tab_b), .match(match_b)
    );

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Evaluate the cell at each visited input and compare against the visited expected bits.
    function automatic logic [16:0] ref_model(input logic [15:0] lut, input logic [15:0] expv,
                                              input int n);
        logic [15:0] t;
        logic [15:0] em;
        t  = '0;
        em = '0;
        for (int i = 0; i < (1 << n); i++) begin
            t[i]  = lut[i];
            em[i] = expv[i];
        end
        return {t == em, t};
    endfunction

    // Drives one sweep; optionally re-pulses start mid-sweep and during the done cycle.
    task automatic run_sweep(input bit use_b, input logic [15:0] lut, input logic [15:0] expv,
                             input bit repulse);
        int          n;
        int          c0;
        int          lat;
        int          waited;
        logic [16:0] r;
        n = use_b ? 2 : 4;
        @(negedge clk);
        if (use_b) begin lut_b = lut; exp_b = expv; start_b = 1'b1; end
        else       begin lut_a = lut; exp_a = expv; start_a = 1'b1; end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        c0  = cyc;
        // Done is high in cycle (2**N_IN)*(W+1)+1, counting the accept edge as cycle 1.
        lat = (1 << n) * 7 + 1;
        r   = ref_model(lut, expv, n);
        exp_q.push_back({use_b, 16'(c0 + lat - 1), r});
        if (repulse) begin
            while (cyc < c0 + 9) @(negedge clk);
            if (use_b) start_b = 1'b1; else start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
            start_b = 1'b0;
        end
        waited = 0;
        while (!(use_b ? done_b : done_a) && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        check("done_timeout", 34'(waited < 300), 34'd1);
        check("busy_in_done", 34'(use_b ? busy_b : busy_a), 34'd1);
        if (repulse) begin
            if (use_b) start_b = 1'b1; else start_a = 1'b1;
        end
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        check("busy_after_done", 34'(use_b ? busy_b : busy_a), 34'd0);
    endtask

    logic [3:0] prev_a = '0, prev_b = '0;

    // Monitor: scoreboard pops on done; probe_in may only count up by one or restart at 0.
    always @(negedge clk) begin
        logic [33:0] e;
        if (done_a || done_b) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", {done_b, done_a}, 34'd0);
            end else begin
                e = exp_q.pop_front();
                check("done_dut", 34'(done_b), 34'(e[33]));
                check("done_cycle", 34'(cyc[15:0]), 34'(e[32:17]));
                check("table_o", 34'(done_b ? tab_b : tab_a), 34'(e[15:0]));
                check("match", 34'(done_b ? match_b : match_a), 34'(e[16]));
            end
        end
        if (pin_a != prev_a) begin
            check("probe_step_a", 34'(pin_a == prev_a + 4'd1 || pin_a == 4'd0), 34'd1);
            prev_a = pin_a;
        end
        if (pin_b != prev_b) begin
            check("probe_step_b", 34'((pin_b == prev_b + 4'd1 || pin_b == 4'd0) && pin_b[3:2] == 2'b00),
                  34'd1);
            prev_b = pin_b;
        end
    end

    initial begin
        logic [15:0] l;
        logic [15:0] x;
        int          c0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_a", {busy_a, done_a, match_a, tab_a, pin_a}, 34'd0);
        check("reset_b", {busy_b, done_b, match_b, tab_b, pin_b}, 34'd0);

        run_sweep(1'b0, 16'hCAFE, 16'hCAFE, 1'b0);
        run_sweep(1'b0, IA ^ IB ^ IC ^ ID, 16'h6996, 1'b0);
        run_sweep(1'b0, 16'hFFFF, 16'h0000, 1'b0);
        run_sweep(1'b1, IA & IB, 16'h0008, 1'b0);
        x = 16'($urandom);
        run_sweep(1'b1, 16'($urandom), {x[15:4], 4'h0}, 1'b0);

        // Re-pulses must be ignored; the follow-up start lands right after DONE.
        l = 16'($urandom);
        run_sweep(1'b0, l, l, 1'b1);
        run_sweep(1'b0, ~l, l, 1'b0);

        // Abort mid-sweep with reset.
        @(negedge clk);
        lut_a = 16'($urandom);
        exp_a = lut_a;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        c0 = cyc;
        while (cyc < c0 + 49) @(negedge clk);
        check("mid_sweep_busy", 34'(busy_a), 34'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_state", {busy_a, done_a, match_a, tab_a, pin_a}, 34'd0);
        repeat (130) @(negedge clk);
        check("abort_idle", 34'(busy_a), 34'd0);

        for (int k = 0; k < 4; k++) begin
            l = 16'($urandom);
            x = ($urandom_range(0, 1) == 1) ? l : 16'($urandom);
            run_sweep(1'b0, l, x, 1'b0);
        end
        for (int k = 0; k < 2; k++) begin
            l = 16'($urandom);
            x = {16'($urandom) & 16'hFFF0} | (l & 16'h000F);
            if ($urandom_range(0, 1) == 1) x[$urandom_range(0, 3)] ^= 1'b1;
            run_sweep(1'b1, l, x, 1'b0);
        end

        repeat (20) @(negedge clk);
        check("scoreboard_empty", 34'(exp_q.size()), 34'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
